// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and default sizing for the register-file dump reader.
package regdump_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;

    // Index reported on the checksum beat.
    localparam logic [DEF_ADDR_W-1:0] CKSUM_IDX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        FIN     = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Control, read-port and output-stream signals of the dump reader.
interface regfile_dump_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] first_idx;
    logic [ADDR_W-1:0] last_idx;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;
    logic              busy;
    logic              done;

    // Requester / register-file / stream-sink side.
    modport master (
        output start, first_idx, last_idx, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, out_idx, out_last, busy, done
    );

    // Dump engine side.
    modport slave (
        input  start, first_idx, last_idx, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, out_idx, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks an index range through a spare read port and streams the words.
// Build option REGDUMP_CHECKSUM_EN appends a wrapping-sum beat after the last register beat.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_dump_reader_if.slave bus
);

    localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              range_ok;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cksum_q, cksum_d;
`endif

    assign range_ok = (bus.first_idx <= bus.last_idx) && (32'(bus.last_idx) < NUM_REGS_U);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q      <= '0;
            cksum_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
            sum_q      <= sum_d;
            cksum_q    <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        sum_d      = sum_q;
        cksum_d    = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (range_ok) begin
                        cur_d   = bus.first_idx;
                        last_d  = bus.last_idx;
                        state_d = READ;
                    end else begin
                        state_d = FIN;
                    end
`ifdef REGDUMP_CHECKSUM_EN
                    sum_d   = '0;
                    cksum_d = 1'b0;
`endif
                end
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
`ifdef REGDUMP_CHECKSUM_EN
                // The checksum beat reuses CAPTURE so out_valid still drops between beats.
                if (cksum_q) begin
                    out_data_d = sum_q;
                    out_idx_d  = CKSUM_IDX;
                    out_last_d = 1'b1;
                end else begin
                    out_data_d = bus.rd_data;
                    out_idx_d  = cur_q;
                    out_last_d = 1'b0;
                    sum_d      = sum_q + bus.rd_data;
                end
`else
                out_data_d = bus.rd_data;
                out_idx_d  = cur_q;
                out_last_d = (cur_q == last_q);
`endif
                state_d = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                    if (cksum_q) begin
                        state_d = FIN;
                    end else if (cur_q == last_q) begin
                        cksum_d = 1'b1;
                        state_d = CAPTURE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = READ;
                    end
`else
                    if (cur_q == last_q) begin
                        state_d = FIN;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = READ;
                    end
`endif
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_en     = (state_q == READ);
    assign bus.rd_addr   = (state_q == READ) ? cur_q : '0;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);

endmodule
